stream_packer: RTL and testbench

STREAM_PACKER -- requirements
Module: stream_packer

---
 rtl/stream_packer.sv | 175 +++++++++++++++++
 tb/tb_stream_packer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/stream_packer.sv
// Purpose: packs variable-count block beats into full NUM_BLOCKS-block output words.
// Latency: one cycle from the accepting input edge to m_valid. A last beat that
//          overflows one word costs one extra output cycle for the remainder.
// Backpressure: s_ready drops while the output register is held (m_valid && !m_ready),
//          while the remainder word is pending (FLUSH state), and during reset.
// Ports:
//   clk, rst_n                       clock and synchronous active-low reset
//   s_data/s_num_blocks/s_last       input word (block 0 at LSB), valid block count, end of packet
//   s_valid/s_ready                  input handshake
//   m_data/m_keep/m_last             packed word, byte enables, end of packet
//   m_valid/m_ready                  output handshake
//   stat_words_out/stat_blocks_in    wrapping counters, present only with STREAM_PACKER_STATS_EN
module stream_packer #(
  parameter int NUM_BLOCKS = 8,
  parameter int BLOCK_SIZE = 32,
  localparam int CW = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_BLOCKS*BLOCK_SIZE-1:0] s_data,
  input  logic [CW-1:0]                    s_num_blocks,
  input  logic                             s_valid,
  input  logic                             s_last,
  output logic                             s_ready,
  output logic [NUM_BLOCKS*BLOCK_SIZE-1:0] m_data,
  output logic [NUM_BLOCKS*BLOCK_SIZE/8-1:0] m_keep,
  output logic                             m_valid,
  output logic                             m_last,
  input  logic                             m_ready
`ifdef STREAM_PACKER_STATS_EN
  ,
  output logic [31:0]                      stat_words_out,
  output logic [31:0]                      stat_blocks_in
`endif
);

  localparam int W  = NUM_BLOCKS * BLOCK_SIZE;
  localparam int BB = BLOCK_SIZE / 8;
  localparam int KW = W / 8;
  localparam logic [CW-1:0] NB = CW'(NUM_BLOCKS);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [2*W-1:0] stage_q, stage_d;
  logic [W-1:0]   data_d;
  logic [KW-1:0]  keep_d;
  logic           valid_d, last_d;

  logic [CW-1:0]  n;
  logic [CW:0]    t;
  logic [W-1:0]   in_masked;
  logic [2*W-1:0] merged;
  logic           accept;

  // Byte enables covering the low k blocks.
  function automatic logic [KW-1:0] keep_mask(input logic [CW:0] k);
    logic [KW-1:0] km;
    km = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (i < int'(k)) km[i*BB +: BB] = '1;
    end
    return km;
  endfunction

  assign s_ready = rst_n && (state_q == ACCUM) && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  // Blocks above the valid count are zeroed so the staging buffer only ever holds
  // live blocks below the fill point; this is what keeps uncovered output blocks zero.
  always_comb begin
    n = (s_num_blocks > NB) ? NB : s_num_blocks;
    in_masked = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (i < int'(n)) in_masked[i*BLOCK_SIZE +: BLOCK_SIZE] = s_data[i*BLOCK_SIZE +: BLOCK_SIZE];
    end
    merged = stage_q | ({{W{1'b0}}, in_masked} << (int'(cnt_q) * BLOCK_SIZE));
    t      = {1'b0, cnt_q} + {1'b0, n};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    stage_d = stage_q;
    valid_d = m_valid && !m_ready;
    data_d  = m_data;
    keep_d  = m_keep;
    last_d  = m_last;
    case (state_q)
      ACCUM: begin
        if (accept && !(n == '0 && !s_last)) begin
          if (!s_last) begin
            if (t >= {1'b0, NB}) begin
              valid_d = 1'b1;
              data_d  = merged[W-1:0];
              keep_d  = '1;
              last_d  = 1'b0;
              stage_d = merged >> W;
              cnt_d   = CW'(t - {1'b0, NB});
            end else begin
              stage_d = merged;
              cnt_d   = t[CW-1:0];
            end
          end else if (t <= {1'b0, NB}) begin
            valid_d = 1'b1;
            data_d  = merged[W-1:0];
            keep_d  = keep_mask(t);
            last_d  = 1'b1;
            stage_d = '0;
            cnt_d   = '0;
          end else begin
            // Overflowing last beat: full word now, remainder from FLUSH.
            valid_d = 1'b1;
            data_d  = merged[W-1:0];
            keep_d  = '1;
            last_d  = 1'b0;
            stage_d = merged >> W;
            rem_d   = CW'(t - {1'b0, NB});
            cnt_d   = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (!m_valid || m_ready) begin
          valid_d = 1'b1;
          data_d  = stage_q[W-1:0];
          keep_d  = keep_mask({1'b0, rem_q});
          last_d  = 1'b1;
          stage_d = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      rem_q   <= '0;
      stage_q <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      stage_q <= stage_d;
      m_valid <= valid_d;
      m_data  <= data_d;
      m_keep  <= keep_d;
      m_last  <= last_d;
    end
  end

`ifdef STREAM_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_words_out <= '0;
      stat_blocks_in <= '0;
    end else begin
      if (m_valid && m_ready) stat_words_out <= stat_words_out + 32'd1;
      if (accept)             stat_blocks_in <= stat_blocks_in + 32'(n);
    end
  end
`endif

endmodule

// File: tb/tb_stream_packer.sv
module tb_stream_packer;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_data;
  logic [2:0]  s_num_blocks;
  logic        s_valid, s_last, s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid, m_last, m_ready;
`ifdef STREAM_PACKER_STATS_EN
  logic [31:0] stat_words_out, stat_blocks_in;
`endif

  int pass_cnt = 0;
  int total    = 0;

  logic [37:0] obs;
  assign obs = {m_valid, m_last, m_keep, m_data};

  stream_packer #(.NUM_BLOCKS(4), .BLOCK_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_num_blocks(s_num_blocks),
    .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
`ifdef STREAM_PACKER_STATS_EN
    , .stat_words_out(stat_words_out), .stat_blocks_in(stat_blocks_in)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // Presents one beat from a negedge, waits (bounded) for s_ready, returns at the
  // negedge after the accepting posedge with s_valid dropped.
  task automatic drive(input logic [31:0] d, input logic [2:0] n, input logic l);
    int waited = 0;
    s_data = d; s_num_blocks = n; s_last = l; s_valid = 1'b1;
    #1;
    while (s_ready !== 1'b1 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    if (s_ready !== 1'b1) begin
      total++;
      $display("FAIL drive_timeout s_ready=%b required 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(negedge clk);
    total++; if (obs !== 38'h0) $display("FAIL reset_out got=%h exp=%h", obs, 38'h0); else pass_cnt++;
    total++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready got=%b exp=0", s_ready); else pass_cnt++;
    rst_n = 1'b1; #1;
    total++; if (s_ready !== 1'b1) $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); else pass_cnt++;
  endtask

  task automatic test_pack();
    drive(32'hEEA2A1A0, 3'd3, 1'b0);
    total++; if (m_valid !== 1'b0) $display("FAIL pack_a_novalid got=%b exp=0", m_valid); else pass_cnt++;
    drive(32'hEEB2B1B0, 3'd3, 1'b0);
    total++; if (obs !== {1'b1, 1'b0, 4'hF, 32'hB0A2A1A0}) $display("FAIL pack_w1 got=%h exp=%h", obs, {1'b1, 1'b0, 4'hF, 32'hB0A2A1A0}); else pass_cnt++;
    drive(32'hEEEEC1C0, 3'd2, 1'b1);
    total++; if (obs !== {1'b1, 1'b1, 4'hF, 32'hC1C0B2B1}) $display("FAIL pack_w2 got=%h exp=%h", obs, {1'b1, 1'b1, 4'hF, 32'hC1C0B2B1}); else pass_cnt++;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) $display("FAIL pack_drain got=%b exp=0", m_valid); else pass_cnt++;
`ifdef STREAM_PACKER_STATS_EN
    total++; if (stat_words_out !== 32'd2) $display("FAIL stat_words got=%0d exp=2", stat_words_out); else pass_cnt++;
    total++; if (stat_blocks_in !== 32'd8) $display("FAIL stat_blocks got=%0d exp=8", stat_blocks_in); else pass_cnt++;
`endif
  endtask

  task automatic test_flush();
    drive(32'hEE131211, 3'd3, 1'b0);
    total++; if (m_valid !== 1'b0) $display("FAIL flush_first_novalid got=%b exp=0", m_valid); else pass_cnt++;
    drive(32'hEE232221, 3'd3, 1'b1);
    total++; if (obs !== {1'b1, 1'b0, 4'hF, 32'h21131211}) $display("FAIL flush_full got=%h exp=%h", obs, {1'b1, 1'b0, 4'hF, 32'h21131211}); else pass_cnt++;
    total++; if (s_ready !== 1'b0) $display("FAIL flush_s_ready got=%b exp=0", s_ready); else pass_cnt++;
    @(negedge clk);
    total++; if (obs !== {1'b1, 1'b1, 4'h3, 32'h00002322}) $display("FAIL flush_rem got=%h exp=%h", obs, {1'b1, 1'b1, 4'h3, 32'h00002322}); else pass_cnt++;
    total++; if (s_ready !== 1'b1) $display("FAIL flush_ready_back got=%b exp=1", s_ready); else pass_cnt++;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) $display("FAIL flush_drain got=%b exp=0", m_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    drive(32'h34333231, 3'd4, 1'b0);
    s_data = 32'hEEEE4241; s_num_blocks = 3'd2; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (obs !== {1'b1, 1'b0, 4'hF, 32'h34333231}) $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs, {1'b1, 1'b0, 4'hF, 32'h34333231}); else pass_cnt++;
      total++; if (s_ready !== 1'b0) $display("FAIL stall_s_ready[%0d] got=%b exp=0", i, s_ready); else pass_cnt++;
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    total++; if (obs !== {1'b1, 1'b1, 4'h3, 32'h00004241}) $display("FAIL stall_release got=%h exp=%h", obs, {1'b1, 1'b1, 4'h3, 32'h00004241}); else pass_cnt++;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) $display("FAIL stall_drain got=%b exp=0", m_valid); else pass_cnt++;
  endtask

  task automatic test_zero_and_clamp();
    drive(32'hFFFFFFFF, 3'd0, 1'b1);
    total++; if (obs !== {1'b1, 1'b1, 4'h0, 32'h00000000}) $display("FAIL zero_last got=%h exp=%h", obs, {1'b1, 1'b1, 4'h0, 32'h00000000}); else pass_cnt++;
    drive(32'hFFFFFFFF, 3'd0, 1'b0);
    total++; if (m_valid !== 1'b0) $display("FAIL zero_noop got=%b exp=0", m_valid); else pass_cnt++;
    drive(32'hEEEEEE51, 3'd1, 1'b1);
    total++; if (obs !== {1'b1, 1'b1, 4'h1, 32'h00000051}) $display("FAIL single_last got=%h exp=%h", obs, {1'b1, 1'b1, 4'h1, 32'h00000051}); else pass_cnt++;
    drive(32'h44434241, 3'd7, 1'b1);
    total++; if (obs !== {1'b1, 1'b1, 4'hF, 32'h44434241}) $display("FAIL clamp got=%h exp=%h", obs, {1'b1, 1'b1, 4'hF, 32'h44434241}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    drive(32'hEEEE6261, 3'd2, 1'b0);
    total++; if (m_valid !== 1'b0) $display("FAIL midrst_novalid got=%b exp=0", m_valid); else pass_cnt++;
    rst_n = 1'b0; #1;
    total++; if (s_ready !== 1'b0) $display("FAIL midrst_s_ready got=%b exp=0", s_ready); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (obs !== 38'h0) $display("FAIL midrst_out got=%h exp=%h", obs, 38'h0); else pass_cnt++;
    drive(32'h74737271, 3'd4, 1'b1);
    total++; if (obs !== {1'b1, 1'b1, 4'hF, 32'h74737271}) $display("FAIL midrst_new got=%h exp=%h", obs, {1'b1, 1'b1, 4'hF, 32'h74737271}); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive(32'h84838281, 3'd4, 1'b0);
    total++; if (obs !== {1'b1, 1'b0, 4'hF, 32'h84838281}) $display("FAIL b2b_w1 got=%h exp=%h", obs, {1'b1, 1'b0, 4'hF, 32'h84838281}); else pass_cnt++;
    total++; if (s_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", s_ready); else pass_cnt++;
    drive(32'h94939291, 3'd4, 1'b0);
    total++; if (obs !== {1'b1, 1'b0, 4'hF, 32'h94939291}) $display("FAIL b2b_w2 got=%h exp=%h", obs, {1'b1, 1'b0, 4'hF, 32'h94939291}); else pass_cnt++;
    drive(32'hA4A3A2A1, 3'd4, 1'b1);
    total++; if (obs !== {1'b1, 1'b1, 4'hF, 32'hA4A3A2A1}) $display("FAIL b2b_w3 got=%h exp=%h", obs, {1'b1, 1'b1, 4'hF, 32'hA4A3A2A1}); else pass_cnt++;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", m_valid); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_data = '0; s_num_blocks = '0; s_last = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_pack();
    test_flush();
    test_backpressure();
    test_zero_and_clamp();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
